alu_cmd_sequencer: RTL and testbench
====================================

# alu_cmd_sequencer

Command-driven issue controller that sits upstream of the 32-bit ALU and drives its `A`, `B` and `sel` inputs. It accepts one command at a time over a valid/ready handshake and reads operands from an internal 8×32 register file. It then presents them to the ALU for one cycle, writes result `C` back to the destination register, and latches `ZF`/`SF` into a flag register. One command completes every 3 cycles.

## Interface
- `DATA_W`, 32, datapath width; must match ALU width
- `REG_N`, 8, number of architectural registers
- `ADDR_W`, 3, register index width (log2 `REG_N`)
- `clk` in 1: single clock; all state updates on rising edge
- `rst` in 1: synchronous, active-high reset
- `cmd_valid` in 1: command present
- `cmd_ready` out 1: sequencer can accept a command
- `cmd_op` in 3: ALU select code, forwarded unchanged to `alu_sel`
- `cmd_rd`, `cmd_rs1`, `cmd_rs2` in `ADDR_W`: destination register and source registers
- `cmd_use_imm` in 1: 1 selects `cmd_imm` as B, 0 selects `reg[cmd_rs2]`
- `cmd_imm` in 16: immediate, zero-extended to `DATA_W`
- `cmd_cond` in 2: execution condition (see Configuration)
- `alu_a`, `alu_b` out `DATA_W`: registered operands to ALU
- `alu_sel` out 3: registered select to ALU
- `alu_c` in `DATA_W`: ALU result
- `alu_zf`, `alu_sf` in 1: ALU zero and sign/carry flags
- `done` out 1: one-cycle pulse when a command retires (executed or skipped)
- `skipped` out 1: valid with `done`; 1 means the condition failed and nothing was written
- `flag_z`, `flag_s` out 1: architectural flags
- `dbg_addr` in `ADDR_W`: debug read address
- `dbg_data` out `DATA_W`: combinational read of `reg[dbg_addr]`

## Operation
- States: `IDLE`, `EXEC`, `DONE`.
- `IDLE`:
  - `cmd_ready=1`.
  - On `cmd_valid&&cmd_ready`, register the operands and select: `alu_a=reg[rs1]`, `alu_b=use_imm?{16'b0,imm}:reg[rs2]`, `alu_sel=op`. Latch `rd` and `cond`. Go to `EXEC`.
- `EXEC`:
  - `cmd_ready=0`; the ALU output settles combinationally.
  - At the clock edge: if the condition passes, write `alu_c` to `reg[rd]` and load `flag_z/flag_s` from `alu_zf/alu_sf`. Otherwise write nothing and leave flags unchanged.
  - Go to `DONE`.
- `DONE`:
  - `done=1`, `skipped` valid, `cmd_ready=0`. Go to `IDLE`.
- `reg[0]` reads as 0 always; writes to r0 are dropped, but flags still update.
- Operand reads use the register values as of the accept edge; there is no forwarding hazard, since only one command is in flight.
- `cmd_valid` held while `cmd_ready=0` is ignored; the command is not lost, just accepted on the next `IDLE` cycle.
- ALU op codes:
  - 000 ADD, 001 SHL, 010 PASS B, 011 SUB
  - 100 XOR, 101 SHR, 110 OR, 111 AND
- `ZF` = 1 when the 33-bit ALU result is zero.
- `SF` = ALU result bit 32 (carry/borrow out).

## Timing
- Reset values:
  - state `IDLE`, `cmd_ready=1`
  - `alu_a=0`, `alu_b=0`, `alu_sel=0`
  - `done=0`, `skipped=0`, `flag_z=0`, `flag_s=0`
  - all registers 0
- Latency: accept at edge N, writeback and flag update at edge N+1, `done` high during cycle N+2, `cmd_ready` high again in cycle N+3.
- Throughput: 1 command per 3 cycles.
- `rst` in any state aborts the in-flight command with no writeback and returns to the reset values on the next edge. `rst` wins over a simultaneous handshake.

## Configuration
- `ALU_COND_EXEC_EN` defined: `cmd_cond` is honoured.
  - 00 always, 01 if `flag_z`, 10 if `flag_s`, 11 if `!flag_z`.
  - Flags are sampled at the `EXEC` edge.
  - A failed condition retires with `done=1`, `skipped=1`.
- Not defined: the `cmd_cond` port exists but is ignored; every command executes and `skipped` is tied 0.

## Structure
- Shared package `alu_pkg`:
  - op-code localparams (`ALU_ADD` … `ALU_AND`)
  - condition codes (`COND_AL`, `COND_Z`, `COND_S`, `COND_NZ`)
  - state encoding
- Sub-module `alu_regfile`: `REG_N`×`DATA_W`, two combinational read ports plus the debug read port, one synchronous write port, r0 hardwired to zero.
- The ALU itself is instantiated beside this block, not inside it.

## Test plan
- Reset, then PASS imm 5 → r1, PASS imm 7 → r2 (`use_imm=1`). Expect `dbg_data(r1)=5`, `dbg_data(r2)=7`, `flag_z=0`, `flag_s=0`, `done` pulse 2 cycles after each accept.
- SUB r3=r1-r2. Expect r3=`0xFFFFFFFE`, `flag_s=1`, `flag_z=0`.
- XOR r4=r1^r1. Expect r4=0, `flag_z=1`. Then ADD r0=r1+r2: expect `dbg_data(r0)=0`, `flag_z=0`.
- Hold `cmd_valid` continuously across 4 commands. Expect `cmd_ready` high exactly 1 of every 3 cycles and 4 `done` pulses in 12 cycles.
- With `ALU_COND_EXEC_EN`: set `flag_z=0`, issue PASS imm 9 → r5 with `cond=01`. Expect `done=1`, `skipped=1`, r5 unchanged. Repeat with `cond=11`: expect r5=9.
- Assert `rst` in `EXEC` of an ADD to r6. Expect r6=0, flags 0 and `cmd_ready=1` on the next cycle, with no `done` pulse.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: ALU op codes, execution
// condition codes, FSM state encoding and the condition evaluator.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SHL  = 3'b001;
  localparam logic [2:0] ALU_PASS = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SHR  = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  localparam logic [1:0] COND_AL = 2'b00;
  localparam logic [1:0] COND_Z  = 2'b01;
  localparam logic [1:0] COND_S  = 2'b10;
  localparam logic [1:0] COND_NZ = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic cond_pass(input logic [1:0] cond,
                                     input logic       fz,
                                     input logic       fs);
    logic ok;
    case (cond)
      COND_AL: ok = 1'b1;
      COND_Z:  ok = fz;
      COND_S:  ok = fs;
      default: ok = !fz;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command handshake, ALU operand/result bus and debug port of the sequencer.
// slave = sequencer side, master = command source / ALU / debug side.
interface alu_cmd_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_rd;
  logic [ADDR_W-1:0] cmd_rs1;
  logic [ADDR_W-1:0] cmd_rs2;
  logic              cmd_use_imm;
  logic [15:0]       cmd_imm;
  logic [1:0]        cmd_cond;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_sel;
  logic [DATA_W-1:0] alu_c;
  logic              alu_zf;
  logic              alu_sf;

  logic              done;
  logic              skipped;
  logic              flag_z;
  logic              flag_s;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_use_imm, cmd_imm, cmd_cond,
    input  alu_c, alu_zf, alu_sf, dbg_addr,
    output cmd_ready, alu_a, alu_b, alu_sel, done, skipped, flag_z, flag_s, dbg_data
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_use_imm, cmd_imm, cmd_cond,
    output alu_c, alu_zf, alu_sf, dbg_addr,
    input  cmd_ready, alu_a, alu_b, alu_sel, done, skipped, flag_z, flag_s, dbg_data
  );
endinterface

// File: rtl/alu_regfile.sv
// REG_N x DATA_W register file: two combinational read ports plus a debug
// read port, one synchronous write port, r0 hardwired to zero.
module alu_regfile #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] rf_view [REG_N];

  for (genvar gi = 0; gi < REG_N; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign rf_view[gi] = '0;
    end else begin : g_store
      logic [DATA_W-1:0] reg_q;
      logic [DATA_W-1:0] reg_d;

      always_comb begin
        reg_d = reg_q;
        if (we && (wr_addr == ADDR_W'(gi))) begin
          reg_d = wr_data;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          reg_q <= '0;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign rf_view[gi] = reg_q;
    end
  end

  assign rd_data_a = rf_view[rd_addr_a];
  assign rd_data_b = rf_view[rd_addr_b];
  assign dbg_data  = rf_view[dbg_addr];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue controller for an external 32-bit ALU: IDLE -> EXEC -> DONE per command.
// Define ALU_COND_EXEC_EN to honour cmd_cond; otherwise every command executes.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_N  = 8,
  parameter int ADDR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  alu_cmd_sequencer_if.slave bus
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [2:0]        alu_sel_q, alu_sel_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_s_q, flag_s_d;
  logic              exec_ok;
  logic              wr_en;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;

  alu_regfile #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (bus.cmd_rs1),
    .rd_addr_b (bus.cmd_rs2),
    .dbg_addr  (bus.dbg_addr),
    .rd_data_a (rs1_data),
    .rd_data_b (rs2_data),
    .dbg_data  (bus.dbg_data),
    .we        (wr_en),
    .wr_addr   (rd_q),
    .wr_data   (bus.alu_c)
  );

`ifdef ALU_COND_EXEC_EN
  logic [1:0] cond_q, cond_d;
  logic       skip_q, skip_d;

  // Flags are sampled in EXEC, i.e. after any earlier command has retired.
  assign exec_ok = cond_pass(cond_q, flag_z_q, flag_s_q);

  always_comb begin
    cond_d = cond_q;
    skip_d = skip_q;
    if (state_q == ST_IDLE && bus.cmd_valid) begin
      cond_d = bus.cmd_cond;
    end
    if (state_q == ST_EXEC) begin
      skip_d = !exec_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cond_q <= COND_AL;
      skip_q <= 1'b0;
    end else begin
      cond_q <= cond_d;
      skip_q <= skip_d;
    end
  end

  assign bus.skipped = (state_q == ST_DONE) && skip_q;
`else
  logic cond_unused;
  assign cond_unused = ^bus.cmd_cond;
  assign exec_ok     = 1'b1;
  assign bus.skipped = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    rd_d      = rd_q;
    flag_z_d  = flag_z_q;
    flag_s_d  = flag_s_q;
    wr_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          alu_a_d   = rs1_data;
          alu_b_d   = bus.cmd_use_imm ? {{(DATA_W-16){1'b0}}, bus.cmd_imm} : rs2_data;
          alu_sel_d = bus.cmd_op;
          rd_d      = bus.cmd_rd;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Flags update even when rd is r0; the regfile drops that write.
        if (exec_ok) begin
          wr_en    = 1'b1;
          flag_z_d = bus.alu_zf;
          flag_s_d = bus.alu_sf;
        end
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      rd_q      <= '0;
      flag_z_q  <= 1'b0;
      flag_s_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      rd_q      <= rd_d;
      flag_z_q  <= flag_z_d;
      flag_s_q  <= flag_s_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.flag_z    = flag_z_q;
  assign bus.flag_s    = flag_s_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU beside the DUT
// and a scoreboard of expected retirements.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  typedef struct {
    logic        skip;
    logic [2:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sel;
    logic [31:0] val;
    logic        z;
    logic        s;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t b2b_exp [4];

  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.DATA_W(32), .ADDR_W(3)) bus ();

  alu_cmd_sequencer #(.DATA_W(32), .REG_N(8), .ADDR_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // External ALU: 33-bit result, ZF on whole result, SF = bit 32
  logic [32:0] alu_res;
  always_comb begin
    case (bus.alu_sel)
      ALU_ADD:  alu_res = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      ALU_SHL:  alu_res = {1'b0, bus.alu_a} << bus.alu_b[4:0];
      ALU_PASS: alu_res = {1'b0, bus.alu_b};
      ALU_SUB:  alu_res = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      ALU_XOR:  alu_res = {1'b0, bus.alu_a ^ bus.alu_b};
      ALU_SHR:  alu_res = {1'b0, bus.alu_a >> bus.alu_b[4:0]};
      ALU_OR:   alu_res = {1'b0, bus.alu_a | bus.alu_b};
      default:  alu_res = {1'b0, bus.alu_a & bus.alu_b};
    endcase
  end
  assign bus.alu_c  = alu_res[31:0];
  assign bus.alu_zf = (alu_res == 33'd0);
  assign bus.alu_sf = alu_res[32];

  function automatic exp_t mk(input logic skip, input logic [2:0] rd,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] sel, input logic [31:0] val,
                              input logic z, input logic s);
    exp_t e;
    e.skip = skip; e.rd = rd; e.a = a; e.b = b;
    e.sel = sel; e.val = val; e.z = z; e.s = s;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic use_imm, input logic [15:0] imm,
                       input logic [1:0] cond);
    bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2;
    bus.cmd_use_imm = use_imm; bus.cmd_imm = imm; bus.cmd_cond = cond;
  endtask

  // Called on a falling edge of a done cycle: pop and verify one retirement.
  task automatic compare_retire();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check("skipped", bus.skipped, e.skip);
    bus.dbg_addr = e.rd;
    #1;
    check("reg_value", bus.dbg_data, e.val);
    check("flag_z", bus.flag_z, e.z);
    check("flag_s", bus.flag_s, e.s);
    $display("txn rd=r%0d val=%h skipped=%b flag_z=%b flag_s=%b",
             e.rd, bus.dbg_data, bus.skipped, bus.flag_z, bus.flag_s);
  endtask

  // Waits (bounded) for cmd_ready, raises cmd_valid for exactly one accept edge.
  task automatic accept_cmd(input exp_t e);
    int n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    sb.push_back(e);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("exec_alu_a", bus.alu_a, e.a);
    check("exec_alu_b", bus.alu_b, e.b);
    check("exec_alu_sel", bus.alu_sel, e.sel);
    check("exec_done_low", bus.done, 0);
  endtask

  task automatic retire();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 8);
    check("done_latency", n, 1);
    compare_retire();
  endtask

  task automatic drive_b2b(input int k);
    case (k)
      0: drive(ALU_PASS, 3'd5, 3'd0, 3'd0, 1'b1, 16'h0011, COND_AL);
      1: drive(ALU_ADD,  3'd6, 3'd1, 3'd2, 1'b0, 16'h0000, COND_AL);
      2: drive(ALU_SUB,  3'd7, 3'd2, 3'd1, 1'b0, 16'h0000, COND_AL);
      default: drive(ALU_OR, 3'd4, 3'd1, 3'd2, 1'b0, 16'h0000, COND_AL);
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, rdy_cnt, done_cnt, n;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.dbg_addr = 3'd0;
    drive(ALU_ADD, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, COND_AL);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.cmd_ready, 1);
    check("rst_done", bus.done, 0);
    check("rst_skipped", bus.skipped, 0);
    check("rst_flag_z", bus.flag_z, 0);
    check("rst_flag_s", bus.flag_s, 0);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_b", bus.alu_b, 0);
    check("rst_alu_sel", bus.alu_sel, 0);
    for (int r = 0; r < 8; r++) begin
      bus.dbg_addr = 3'(r);
      #1;
      check("rst_reg", bus.dbg_data, 0);
    end
    @(negedge clk);
    rst = 1'b0;

    drive(ALU_PASS, 3'd1, 3'd0, 3'd0, 1'b1, 16'd5, COND_AL);
    accept_cmd(mk(1'b0, 3'd1, 32'd0, 32'd5, ALU_PASS, 32'd5, 1'b0, 1'b0));
    retire();
    drive(ALU_PASS, 3'd2, 3'd0, 3'd0, 1'b1, 16'd7, COND_AL);
    accept_cmd(mk(1'b0, 3'd2, 32'd0, 32'd7, ALU_PASS, 32'd7, 1'b0, 1'b0));
    retire();
    drive(ALU_SUB, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0, COND_AL);
    accept_cmd(mk(1'b0, 3'd3, 32'd5, 32'd7, ALU_SUB, 32'hFFFF_FFFE, 1'b0, 1'b1));
    retire();
    drive(ALU_XOR, 3'd4, 3'd1, 3'd1, 1'b0, 16'd0, COND_AL);
    accept_cmd(mk(1'b0, 3'd4, 32'd5, 32'd5, ALU_XOR, 32'd0, 1'b1, 1'b0));
    retire();
    drive(ALU_ADD, 3'd0, 3'd1, 3'd2, 1'b0, 16'd0, COND_AL);
    accept_cmd(mk(1'b0, 3'd0, 32'd5, 32'd7, ALU_ADD, 32'd0, 1'b0, 1'b0));
    retire();

    // Back-to-back with cmd_valid held: ready 1 of every 3 cycles
    b2b_exp[0] = mk(1'b0, 3'd5, 32'd0, 32'h11, ALU_PASS, 32'h11, 1'b0, 1'b0);
    b2b_exp[1] = mk(1'b0, 3'd6, 32'd5, 32'd7, ALU_ADD, 32'd12, 1'b0, 1'b0);
    b2b_exp[2] = mk(1'b0, 3'd7, 32'd7, 32'd5, ALU_SUB, 32'd2, 1'b0, 1'b0);
    b2b_exp[3] = mk(1'b0, 3'd4, 32'd5, 32'd7, ALU_OR, 32'd7, 1'b0, 1'b0);
    idx = 0; rdy_cnt = 0; done_cnt = 0;
    drive_b2b(0);
    bus.cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      check("b2b_ready_pattern", bus.cmd_ready, (cyc % 3 == 0));
      if (bus.cmd_ready) rdy_cnt++;
      if (bus.done) begin
        done_cnt++;
        compare_retire();
      end
      if (bus.cmd_ready && idx < 4) begin
        @(posedge clk);
        sb.push_back(b2b_exp[idx]);
        idx++;
        #1;
        if (idx < 4) drive_b2b(idx);
        else bus.cmd_valid = 1'b0;
      end
    end
    bus.cmd_valid = 1'b0;
    check("b2b_ready_count", rdy_cnt, 4);
    check("b2b_done_count", done_cnt, 4);

`ifdef ALU_COND_EXEC_EN
    drive(ALU_PASS, 3'd5, 3'd0, 3'd0, 1'b1, 16'd9, COND_Z);
    accept_cmd(mk(1'b1, 3'd5, 32'd0, 32'd9, ALU_PASS, 32'h11, 1'b0, 1'b0));
    retire();
    drive(ALU_PASS, 3'd5, 3'd0, 3'd0, 1'b1, 16'd9, COND_NZ);
    accept_cmd(mk(1'b0, 3'd5, 32'd0, 32'd9, ALU_PASS, 32'd9, 1'b0, 1'b0));
    retire();
`else
    drive(ALU_PASS, 3'd5, 3'd0, 3'd0, 1'b1, 16'd9, COND_Z);
    accept_cmd(mk(1'b0, 3'd5, 32'd0, 32'd9, ALU_PASS, 32'd9, 1'b0, 1'b0));
    retire();
`endif

    // Leave flag_s set so the abort below has a flag to clear
    drive(ALU_SUB, 3'd7, 3'd1, 3'd2, 1'b0, 16'd0, COND_AL);
    accept_cmd(mk(1'b0, 3'd7, 32'd5, 32'd7, ALU_SUB, 32'hFFFF_FFFE, 1'b0, 1'b1));
    retire();

    // Reset during EXEC of ADD r6 aborts without writeback or done
    drive(ALU_ADD, 3'd6, 3'd1, 3'd2, 1'b0, 16'd0, COND_AL);
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_ready", bus.cmd_ready, 1);
    check("abort_done", bus.done, 0);
    check("abort_flag_z", bus.flag_z, 0);
    check("abort_flag_s", bus.flag_s, 0);
    bus.dbg_addr = 3'd6;
    #1 check("abort_r6", bus.dbg_data, 0);
    bus.dbg_addr = 3'd1;
    #1 check("abort_r1", bus.dbg_data, 0);
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) n++;
    end
    check("abort_no_done", n, 0);
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
